// File: rtl/adc_frame_pack.sv
// ADC frame capture: after each falling sync edge, optionally waits a latched delay,
// then packs pairs of samples into 32-bit words for a ping-pong buffered write port.
`timescale 1ns/1ps
module adc_frame_pack #(
  parameter int ADC_W  = 12,
  parameter int ADDR_W = 12,
  parameter int DLY_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sync,
  input  logic [ADC_W-1:0]  i_adc_data,
  input  logic [DLY_W-1:0]  i_delay,
  input  logic [ADDR_W-2:0] i_len_words,
  input  logic              i_clr_ovr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_rd_bank,
  output logic              o_overrun
);

  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DONE} state_e;

  state_e            state_q, state_d;
  logic              sync_q;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [ADDR_W-2:0] len_q, len_d;
  logic [ADDR_W-2:0] word_q, word_d;
  logic              phase_q, phase_d;
  logic [ADC_W-1:0]  hold_q, hold_d;
  logic              bank_q, bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              ovr_q, ovr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              sync_fall;

  assign sync_fall = sync_q & ~i_sync;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    len_d     = len_q;
    word_d    = word_q;
    phase_d   = phase_q;
    hold_d    = hold_q;
    bank_d    = bank_q;
    rd_bank_d = rd_bank_q;
    ovr_d     = ovr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (sync_fall && (i_len_words != '0)) begin
          dly_d   = i_delay;
          len_d   = i_len_words;
          word_d  = '0;
          phase_d = 1'b0;
          state_d = (i_delay == '0) ? CAPTURE : DELAY;
        end
      end
      DELAY: begin
        if (dly_q == DLY_W'(1)) state_d = CAPTURE;
        else                    dly_d   = dly_q - DLY_W'(1);
      end
      CAPTURE: begin
        // word_q reaching len_q marks the cycle the final word is on the port
        if (word_q == len_q) begin
          state_d = DONE;
        end else if (!phase_q) begin
          hold_d  = i_adc_data;
          phase_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = {16'(i_adc_data), 16'(hold_q)};
          wr_addr_d = {bank_q, word_q};
          phase_d   = 1'b0;
          word_d    = word_q + 1'b1;
        end
      end
      DONE: begin
        rd_bank_d = bank_q;
        bank_d    = ~bank_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_clr_ovr) ovr_d = 1'b0;
    if (sync_fall && (state_q != IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= 1'b1;
      dly_q     <= '0;
      len_q     <= '0;
      word_q    <= '0;
      phase_q   <= 1'b0;
      hold_q    <= '0;
      bank_q    <= 1'b0;
      rd_bank_q <= 1'b0;
      ovr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= i_sync;
      dly_q     <= dly_d;
      len_q     <= len_d;
      word_q    <= word_d;
      phase_q   <= phase_d;
      hold_q    <= hold_d;
      bank_q    <= bank_d;
      rd_bank_q <= rd_bank_d;
      ovr_q     <= ovr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = (state_q == DONE);
  assign o_rd_bank    = rd_bank_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_adc_frame_pack.sv
// Directed bench for adc_frame_pack: framing, delay timing, banks, overrun, zero length, reset abort.
`timescale 1ns/1ps
module tb_adc_frame_pack;
  localparam int ADC_W  = 12;
  localparam int ADDR_W = 12;
  localparam int DLY_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_sync = 1'b1;
  logic [ADC_W-1:0]  i_adc_data = '0;
  logic [DLY_W-1:0]  i_delay = '0;
  logic [ADDR_W-2:0] i_len_words = '0;
  logic              i_clr_ovr = 1'b0;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_wr_en, o_busy, o_frame_done, o_rd_bank, o_overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W+31:0] wr_log[$];
  int done_cnt = 0;

  adc_frame_pack #(.ADC_W(ADC_W), .ADDR_W(ADDR_W), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_adc_data(i_adc_data),
    .i_delay(i_delay), .i_len_words(i_len_words), .i_clr_ovr(i_clr_ovr),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_rd_bank(o_rd_bank),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (o_wr_en) wr_log.push_back({o_wr_addr, o_wr_data});
      if (o_frame_done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; ADC presents a ramp that steps just after each edge.
  task automatic tick();
    @(posedge clk);
    #1;
    i_adc_data = i_adc_data + 1'b1;
  endtask

  // Sample taken at E+k carries base+k, where E is the detected sync edge.
  task automatic start_frame(input logic [DLY_W-1:0] d, input logic [ADDR_W-2:0] l,
                             input logic [ADC_W-1:0] base);
    i_delay     = d;
    i_len_words = l;
    i_adc_data  = base;
    i_sync      = 1'b0;
    tick();
    i_sync      = 1'b1;
    i_delay     = '1;
    i_len_words = '1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && o_busy; i++) tick();
    check(tag, o_busy, 1'b0);
  endtask

  task automatic check_entry(input string tag, input int idx,
                             input logic [ADDR_W-1:0] a, input logic [31:0] dat);
    logic [ADDR_W+31:0] e;
    e = (idx < wr_log.size()) ? wr_log[idx] : '1;
    check({tag, "_addr"}, e[ADDR_W+31:32], a);
    check({tag, "_data"}, e[31:0], dat);
  endtask

  int n0, d0;

  initial begin
    tick(); tick();
    check("rst_wr_en", o_wr_en, 1'b0);
    check("rst_addr", o_wr_addr, '0);
    check("rst_data", o_wr_data, '0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_frame_done, 1'b0);
    check("rst_rd_bank", o_rd_bank, 1'b0);
    check("rst_ovr", o_overrun, 1'b0);
    rst_n = 1'b1;
    tick(); tick();

    // Basic frame D=0 L=4, first captured sample 0x010
    n0 = wr_log.size(); d0 = done_cnt;
    start_frame(16'd0, 11'd4, 12'h00F);
    wait_idle("basic_idle");
    tick();
    check("basic_nwr", wr_log.size() - n0, 4);
    check_entry("basic_w0", n0 + 0, 12'h000, 32'h00110010);
    check_entry("basic_w1", n0 + 1, 12'h001, 32'h00130012);
    check_entry("basic_w2", n0 + 2, 12'h002, 32'h00150014);
    check_entry("basic_w3", n0 + 3, 12'h003, 32'h00170016);
    check("basic_done", done_cnt - d0, 1);
    check("basic_rd_bank", o_rd_bank, 1'b0);

    // Delay timing D=5 L=1, now filling bank 1
    start_frame(16'd5, 11'd1, 12'h100);
    for (int i = 0; i < 6; i++) tick();
    check("dly_early_wr", o_wr_en, 1'b0);
    tick();
    check("dly_wr_en", o_wr_en, 1'b1);
    check("dly_addr", o_wr_addr, 12'h800);
    check("dly_data", o_wr_data, 32'h01070106);
    check("dly_done_early", o_frame_done, 1'b0);
    tick();
    check("dly_wr_off", o_wr_en, 1'b0);
    check("dly_done", o_frame_done, 1'b1);
    check("dly_busy_done", o_busy, 1'b1);
    tick();
    check("dly_busy_off", o_busy, 1'b0);
    check("dly_done_off", o_frame_done, 1'b0);
    check("dly_rd_bank", o_rd_bank, 1'b1);

    // Ping-pong: three L=2 frames
    for (int f = 0; f < 3; f++) begin
      logic [ADDR_W-1:0] b;
      b = (f == 1) ? 12'h800 : 12'h000;
      n0 = wr_log.size();
      start_frame(16'd0, 11'd2, 12'h200);
      wait_idle("pp_idle");
      tick();
      check("pp_nwr", wr_log.size() - n0, 2);
      check_entry("pp_w0", n0, b, 32'h02020201);
      check_entry("pp_w1", n0 + 1, b + 12'h001, 32'h02040203);
      check("pp_rd_bank", o_rd_bank, (f == 1));
    end

    // Overrun: second edge mid-capture, L=8 in bank 1
    n0 = wr_log.size(); d0 = done_cnt;
    start_frame(16'd0, 11'd8, 12'h300);
    for (int i = 0; i < 5; i++) tick();
    i_sync = 1'b0;
    tick();
    i_sync = 1'b1;
    wait_idle("ovr_idle");
    tick();
    check("ovr_nwr", wr_log.size() - n0, 8);
    check_entry("ovr_w7", n0 + 7, 12'h807, 32'h0310030F);
    check("ovr_done", done_cnt - d0, 1);
    check("ovr_set", o_overrun, 1'b1);
    tick(); tick();
    check("ovr_sticky", o_overrun, 1'b1);
    start_frame(16'd0, 11'd3, 12'h000);
    tick(); tick();
    i_sync = 1'b0; i_clr_ovr = 1'b1;
    tick();
    i_sync = 1'b1; i_clr_ovr = 1'b0;
    check("ovr_set_wins", o_overrun, 1'b1);
    wait_idle("ovr2_idle");
    i_clr_ovr = 1'b1;
    tick();
    i_clr_ovr = 1'b0;
    check("ovr_clear", o_overrun, 1'b0);

    // Zero length edge is ignored
    n0 = wr_log.size(); d0 = done_cnt;
    start_frame(16'd0, 11'd0, 12'h000);
    check("zero_busy", o_busy, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("zero_nwr", wr_log.size() - n0, 0);
    check("zero_done", done_cnt - d0, 0);
    check("zero_ovr", o_overrun, 1'b0);

    // Reset mid-frame after 3 of 6 words (frame in bank 1)
    n0 = wr_log.size(); d0 = done_cnt;
    start_frame(16'd0, 11'd6, 12'h400);
    for (int i = 0; i < 7; i++) tick();
    check("abort_nwr", wr_log.size() - n0, 3);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 1'b0);
    check("abort_outs", {o_wr_en, o_frame_done, o_rd_bank, o_overrun, o_wr_addr, o_wr_data}, '0);
    tick();
    rst_n = 1'b1;
    tick();
    n0 = wr_log.size();
    start_frame(16'd0, 11'd1, 12'h500);
    wait_idle("post_idle");
    tick();
    check("post_nwr", wr_log.size() - n0, 1);
    check_entry("post_w0", n0, 12'h000, 32'h05020501);
    check("post_done", done_cnt - d0, 1);
    check("post_rd_bank", o_rd_bank, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
